fifo_burst_reader: RTL and testbench
====================================

Name: fifo_burst_reader

Overview:
- Drains a `fifo` core from its reader side and emits fixed-length bursts on a registered valid/ready stream with an end-of-burst marker.
- Starts a full burst once BURST words are stored.
- Flushes a shorter partial burst when words sit unread for TIMEOUT cycles.
- Sits between packet/DMA engines and the fifo core.

Parameters:
- WIDTH, 32, data word width; equals the FIFO WIDTH.
- DEPTH, 32, FIFO depth; sets fifo_fill_level width FILLBITS = $clog2(DEPTH+1).
- BURST, 8, full burst length in words; 1 <= BURST <= DEPTH.
- TIMEOUT, 64, idle cycles before a partial flush; 0 disables partial bursts.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  allows new bursts to start; does not abort a running burst.
- fifo_dataout  in  WIDTH  FIFO head word, valid whenever fifo_empty=0.
- fifo_empty  in  1  FIFO empty flag (registered in FIFO).
- fifo_fill_level  in  FILLBITS  FIFO occupancy (registered in FIFO).
- fifo_read  out  1  pop strobe, one word per asserted cycle (combinational).
- m_data  out  WIDTH  stream data (registered).
- m_valid  out  1  stream valid (registered).
- m_last  out  1  last word of the current burst (registered, qualified by m_valid).
- m_ready  in  1  downstream accept.
- burst_len  out  $clog2(BURST+1)  length of the current or most recent burst (registered).
- busy  out  1  high while state=BURST.

Behaviour:
- Reset values: state=IDLE, fifo_read=0, m_valid=0, m_last=0, m_data=0, burst_len=0, busy=0, remaining=0, timer=0. Reset mid-burst aborts it; words already popped and the held output word are discarded.
- FIFO contract: fifo_dataout presents the head. Asserting fifo_read at edge t pops it. Flags and fill level reflect the pop after edge t, so a read every cycle while fifo_empty=0 is legal.
- States: IDLE, BURST.
- IDLE -> BURST, full burst: enable=1 and fifo_fill_level >= BURST. Load remaining=burst_len=BURST; timer<=0. Has priority over a partial burst.
- IDLE -> BURST, partial burst: enable=1, TIMEOUT>0, 0 < fill < BURST and timer == TIMEOUT-1. Load remaining=burst_len=fifo_fill_level.
- Timer in IDLE: increments when enable=1 and 0 < fill < BURST. Clears otherwise, and on any burst start. Saturates; never wraps.
- No read occurs in the transition cycle. The first pop is the cycle after BURST is entered.
- fifo_read = (state==BURST) && !fifo_empty && (!m_valid || m_ready).
- On fifo_read: m_data<=fifo_dataout, m_valid<=1, m_last<=(remaining==1), remaining<=remaining-1.
- On fifo_read with remaining==1: state<=IDLE. A new burst may be detected in that next IDLE cycle.
- When m_valid && m_ready && !fifo_read: m_valid<=0, m_last<=0.
- Latency: FIFO head to m_valid is 1 cycle. Throughput is 1 word/cycle while m_ready=1.
- Backpressure: m_data, m_valid and m_last hold stable while m_valid=1 and m_ready=0; no pop occurs.
- fifo_empty=1 during BURST (FIFO externally reset or misused): stall, no pop, state held.
- enable dropping mid-burst: the burst completes fully.
- Bursts never overlap. burst_len holds until the next burst start.
- FIFO writes during a burst do not change remaining.

Test Plan:
- Fill the FIFO with 8 words 0x10..0x17, enable=1, m_ready=1 -> in IDLE with fill=8, BURST entered; fifo_read high on the 8 following cycles; m_data 0x10..0x17 one cycle later; m_last only with 0x17; burst_len=8.
- Write 3 words, TIMEOUT=64, no further writes -> after 64 IDLE cycles with fill=3, partial burst of 3; m_last on the 3rd word; burst_len=3. Repeat with TIMEOUT=0 -> no burst ever.
- Full burst with m_ready toggling 1,0,0,1,... -> no pop while m_valid=1 and m_ready=0; held data stable; all 8 words delivered in order, none duplicated.
- Fill 16 words, m_ready=1 -> two back-to-back bursts. Second BURST entry occurs 1 cycle after the first burst's last pop. m_last asserted exactly twice.
- Drop enable after the 2nd word of a burst -> remaining 6 words still delivered. Afterwards, no burst starts despite fill >= 8 until enable=1.
- Assert reset on the 4th word of a burst -> next cycle: m_valid=0, busy=0, fifo_read=0, state IDLE. The remaining 4 words stay in the FIFO and form the next burst with a refill.

Source files
------------

// File: rtl/fifo_burst_reader.sv
// Drains a FIFO from its read side and emits fixed-length bursts on a registered
// valid/ready stream, flushing a shorter partial burst after an idle timeout.
module fifo_burst_reader #(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned DEPTH    = 32,
   parameter int unsigned BURST    = 8,
   parameter int unsigned TIMEOUT  = 64,
   localparam int unsigned FILLBITS = $clog2(DEPTH + 1),
   localparam int unsigned LENBITS  = $clog2(BURST + 1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic [WIDTH-1:0]    fifo_dataout,
   input  logic                fifo_empty,
   input  logic [FILLBITS-1:0] fifo_fill_level,
   output logic                fifo_read,
   output logic [WIDTH-1:0]    m_data,
   output logic                m_valid,
   output logic                m_last,
   input  logic                m_ready,
   output logic [LENBITS-1:0]  burst_len,
   output logic                busy
);

   // Timer only needs to reach TIMEOUT-1; it saturates at all-ones.
   localparam int unsigned TimerW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   typedef enum logic [0:0] {StIdle, StBurst} state_e;

   state_e              state_q, state_d;
   logic [TimerW-1:0]   timer_q, timer_d;
   logic [LENBITS-1:0]  remaining_q, remaining_d;
   logic [LENBITS-1:0]  burst_len_q, burst_len_d;
   logic [WIDTH-1:0]    m_data_q, m_data_d;
   logic                m_valid_q, m_valid_d;
   logic                m_last_q, m_last_d;

   logic fill_full;
   logic fill_part;
   logic start_full;
   logic start_part;
   logic last_pop;

   assign fill_full  = fifo_fill_level >= FILLBITS'(BURST);
   assign fill_part  = (fifo_fill_level != '0) && !fill_full;
   assign start_full = (state_q == StIdle) && enable && fill_full;
   assign start_part = (TIMEOUT != 0) && (state_q == StIdle) && enable && fill_part &&
                       (timer_q == TimerW'(TIMEOUT - 1));
   assign last_pop   = fifo_read && (remaining_q == LENBITS'(1));

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start_full || start_part) begin
               state_d = StBurst;
            end
         end
         StBurst: begin
            if (last_pop) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs; no pop is issued while reset is held so the FIFO keeps its words.
   always_comb begin
      fifo_read = !reset && (state_q == StBurst) && !fifo_empty && (!m_valid_q || m_ready);
      busy      = (state_q == StBurst);
   end

   // Datapath next-state
   always_comb begin
      timer_d     = timer_q;
      remaining_d = remaining_q;
      burst_len_d = burst_len_q;
      m_data_d    = m_data_q;
      m_valid_d   = m_valid_q;
      m_last_d    = m_last_q;

      if (state_q == StIdle) begin
         if (start_full) begin
            timer_d     = '0;
            remaining_d = LENBITS'(BURST);
            burst_len_d = LENBITS'(BURST);
         end else if (start_part) begin
            timer_d     = '0;
            remaining_d = LENBITS'(fifo_fill_level);
            burst_len_d = LENBITS'(fifo_fill_level);
         end else if (enable && fill_part) begin
            if (timer_q != '1) begin
               timer_d = timer_q + 1'b1;
            end
         end else begin
            timer_d = '0;
         end
      end else begin
         timer_d = '0;
      end

      if (fifo_read) begin
         m_data_d    = fifo_dataout;
         m_valid_d   = 1'b1;
         m_last_d    = (remaining_q == LENBITS'(1));
         remaining_d = remaining_q - 1'b1;
      end else if (m_valid_q && m_ready) begin
         m_valid_d = 1'b0;
         m_last_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         timer_q     <= '0;
         remaining_q <= '0;
         burst_len_q <= '0;
         m_data_q    <= '0;
         m_valid_q   <= 1'b0;
         m_last_q    <= 1'b0;
      end else begin
         timer_q     <= timer_d;
         remaining_q <= remaining_d;
         burst_len_q <= burst_len_d;
         m_data_q    <= m_data_d;
         m_valid_q   <= m_valid_d;
         m_last_q    <= m_last_d;
      end
   end

   assign m_data    = m_data_q;
   assign m_valid   = m_valid_q;
   assign m_last    = m_last_q;
   assign burst_len = burst_len_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: FIFO model, scoreboard monitor on the stream side,
// directed timing checks plus randomized phases.
module tb_fifo_burst_reader;

   localparam int unsigned WIDTH   = 32;
   localparam int unsigned DEPTH   = 32;
   localparam int unsigned BURST   = 8;
   localparam int unsigned TIMEOUT = 64;
   localparam int unsigned FB      = $clog2(DEPTH + 1);
   localparam int unsigned LB      = $clog2(BURST + 1);

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             enable = 1'b0;
   logic [WIDTH-1:0] fifo_dataout = '0;
   logic             fifo_empty = 1'b1;
   logic [FB-1:0]    fifo_fill_level = '0;
   logic             fifo_read;
   logic [WIDTH-1:0] m_data;
   logic             m_valid;
   logic             m_last;
   logic             m_ready = 1'b1;
   logic [LB-1:0]    burst_len;
   logic             busy;

   logic             rd0, valid0, last0, busy0;
   logic [WIDTH-1:0] data0;
   logic [LB-1:0]    len0;

   always #5 clk = ~clk;

   fifo_burst_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BURST(BURST), .TIMEOUT(TIMEOUT)) u_dut (
      .clk(clk), .reset(reset), .enable(enable), .fifo_dataout(fifo_dataout),
      .fifo_empty(fifo_empty), .fifo_fill_level(fifo_fill_level), .fifo_read(fifo_read),
      .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
      .burst_len(burst_len), .busy(busy)
   );

   // Same block with partial bursts disabled, parked with 3 words that never form a burst.
   fifo_burst_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BURST(BURST), .TIMEOUT(0)) u_dut0 (
      .clk(clk), .reset(reset), .enable(1'b1), .fifo_dataout(32'hdead_beef),
      .fifo_empty(1'b0), .fifo_fill_level(FB'(3)), .fifo_read(rd0),
      .m_data(data0), .m_valid(valid0), .m_last(last0), .m_ready(1'b1),
      .burst_len(len0), .busy(busy0)
   );

   // FIFO model with registered flags
   logic [WIDTH-1:0] fq[$];
   logic             wr_en = 1'b0;
   logic [WIDTH-1:0] wr_data = '0;

   always @(posedge clk) begin
      if (fifo_read && fq.size() > 0) void'(fq.pop_front());
      if (wr_en && fq.size() < DEPTH) fq.push_back(wr_data);
      fifo_empty      <= (fq.size() == 0);
      fifo_fill_level <= FB'(fq.size());
      fifo_dataout    <= (fq.size() != 0) ? fq[0] : '0;
   end

   // Downstream ready: 0 = always, 1 = random, 2 = pattern 1,0,0
   int ready_mode = 0;
   int rcnt = 0;
   always @(posedge clk) begin
      #1;
      if (ready_mode == 0) m_ready = 1'b1;
      else if (ready_mode == 1) m_ready = ($urandom_range(0, 1) == 1);
      else m_ready = ((rcnt % 3) == 0);
      rcnt = rcnt + 1;
   end

   int total = 0;
   int bad = 0;

   logic [WIDTH-1:0] exp_d[$];
   logic             exp_l[$];
   int               exp_n[$];

   // Burst grouping of a run of `tot` words: full groups of BURST, then a remainder.
   task automatic push_exp(input logic [WIDTH-1:0] d, input int p, input int tot);
      int gs, blen;
      gs   = (p / BURST) * BURST;
      blen = (tot - gs >= int'(BURST)) ? int'(BURST) : tot - gs;
      exp_d.push_back(d);
      exp_l.push_back((p - gs) == blen - 1);
      exp_n.push_back(blen);
   endtask

   // Scoreboard monitor, sampled on the falling edge
   bit               chk_en = 1'b0;
   int               beats = 0;
   int               lasts = 0;
   bit               hold_q = 1'b0;
   logic [WIDTH-1:0] hold_d = '0;
   logic             hold_l = 1'b0;

   always @(negedge clk) begin
      if (!reset && chk_en) begin
         if (hold_q) begin
            total++;
            if (!(m_valid && m_data == hold_d && m_last == hold_l)) begin
               bad++;
               $display("FAIL hold: valid=%0b data=%h last=%0b, want valid=1 data=%h last=%0b",
                        m_valid, m_data, m_last, hold_d, hold_l);
            end
         end
         if (m_valid && !m_ready) begin
            total++;
            if (fifo_read) begin
               bad++;
               $display("FAIL stall_pop: fifo_read=1 while stalled, want 0");
            end
         end
         if (m_valid && m_ready) begin
            beats++;
            if (m_last) lasts++;
            total++;
            if (exp_d.size() == 0) begin
               bad++;
               $display("FAIL beat: unexpected word %h last=%0b", m_data, m_last);
            end else begin
               logic [WIDTH-1:0] ed;
               logic             el;
               int               en;
               ed = exp_d.pop_front();
               el = exp_l.pop_front();
               en = exp_n.pop_front();
               if (m_data != ed || m_last != el) begin
                  bad++;
                  $display("FAIL beat: got %h last=%0b, want %h last=%0b", m_data, m_last, ed, el);
               end
               if (el) begin
                  total++;
                  if (int'(burst_len) != en) begin
                     bad++;
                     $display("FAIL burst_len: got %0d want %0d", burst_len, en);
                  end
               end
            end
         end
         hold_q = m_valid && !m_ready;
         hold_d = m_data;
         hold_l = m_last;
      end else begin
         hold_q = 1'b0;
      end
   end

   int t0_cnt = 0;
   always @(negedge clk) begin
      if (!reset && (rd0 || busy0)) t0_cnt++;
   end

   task automatic check(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic load(input int n, input bit seq, input logic [WIDTH-1:0] base, input int pre,
                       input bit push);
      logic [WIDTH-1:0] w[$];
      for (int i = 0; i < n; i++) begin
         logic [WIDTH-1:0] d;
         d = seq ? base + WIDTH'(i) : $urandom;
         w.push_back(d);
         if (push) push_exp(d, pre + i, pre + n);
      end
      foreach (w[i]) begin
         wr_en   = 1'b1;
         wr_data = w[i];
         @(posedge clk);
         #1;
      end
      wr_en = 1'b0;
   endtask

   task automatic drain();
      for (int c = 0; c < 3000 && exp_d.size() != 0; c++) @(posedge clk);
      check("drain_left", exp_d.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Negedges until fifo_read is seen (counting the current cycle as 1), -1 if never.
   task automatic wait_read(output int n, input int lim);
      n = -1;
      for (int c = 1; c <= lim; c++) begin
         @(negedge clk);
         if (fifo_read) begin
            n = c;
            break;
         end
      end
   endtask

   task automatic run_len(input logic lvl, output int r);
      r = 1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (fifo_read == lvl) r++;
         else break;
      end
   endtask

   initial begin
      int n, r, z, l0, b0, bc, rc;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_valid", int'(m_valid), 0);
      check("rst_last", int'(m_last), 0);
      check("rst_data", int'(m_data), 0);
      check("rst_len", int'(burst_len), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_read", int'(fifo_read), 0);
      @(posedge clk);
      #1 chk_en = 1'b1;

      // Full burst of 0x10..0x17
      load(8, 1'b1, 32'h10, 0, 1'b1);
      l0 = lasts;
      enable = 1'b1;
      wait_read(n, 20);
      check("full_lat", n, 2);
      run_len(1'b1, r);
      check("full_run", r, 8);
      drain();
      check("full_lasts", lasts - l0, 1);
      check("idle_busy", int'(busy), 0);

      // Partial flush after TIMEOUT idle cycles
      enable = 1'b0;
      load(3, 1'b0, '0, 0, 1'b1);
      enable = 1'b1;
      wait_read(n, 200);
      check("part_lat", n, int'(TIMEOUT) + 1);
      run_len(1'b1, r);
      check("part_run", r, 3);
      drain();

      // Backpressure pattern
      ready_mode = 2;
      enable = 1'b0;
      b0 = beats;
      load(8, 1'b1, 32'h20, 0, 1'b1);
      enable = 1'b1;
      drain();
      check("bp_beats", beats - b0, 8);

      // Back-to-back bursts
      ready_mode = 0;
      enable = 1'b0;
      load(16, 1'b1, 32'h30, 0, 1'b1);
      l0 = lasts;
      enable = 1'b1;
      wait_read(n, 20);
      check("b2b_lat", n, 2);
      run_len(1'b1, r);
      check("b2b_run1", r, 8);
      run_len(1'b0, z);
      check("b2b_gap", z, 1);
      run_len(1'b1, r);
      check("b2b_run2", r, 8);
      drain();
      check("b2b_lasts", lasts - l0, 2);

      // Enable dropped mid-burst
      enable = 1'b0;
      load(8, 1'b0, '0, 0, 1'b1);
      b0 = beats;
      enable = 1'b1;
      for (int c = 0; c < 50 && beats < b0 + 2; c++) @(negedge clk);
      @(posedge clk);
      #1 enable = 1'b0;
      drain();
      check("drop_beats", beats - b0, 8);
      load(8, 1'b0, '0, 0, 1'b1);
      bc = 0;
      repeat (100) begin
         @(negedge clk);
         if (busy || fifo_read) bc++;
      end
      check("drop_nostart", bc, 0);
      check("drop_fill", fq.size(), 8);
      @(posedge clk);
      #1 enable = 1'b1;
      drain();

      // Randomized phases
      ready_mode = 1;
      repeat (6) begin
         enable = 1'b1;
         load($urandom_range(1, 30), 1'b0, '0, 0, 1'b1);
         drain();
      end

      // Reset in the middle of a burst
      ready_mode = 0;
      enable = 1'b0;
      load(8, 1'b0, '0, 0, 1'b0);
      chk_en = 1'b0;
      enable = 1'b1;
      rc = 0;
      for (int c = 0; c < 50 && rc < 4; c++) begin
         @(negedge clk);
         if (fifo_read) rc++;
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      enable = 1'b0;
      @(negedge clk);
      check("mid_rst_read", int'(fifo_read), 0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("post_rst_valid", int'(m_valid), 0);
      check("post_rst_busy", int'(busy), 0);
      check("post_rst_read", int'(fifo_read), 0);
      check("post_rst_left", fq.size(), 4);
      @(posedge clk);
      #1;
      for (int i = 0; i < fq.size(); i++) push_exp(fq[i], i, 8);
      chk_en = 1'b1;
      load(4, 1'b0, '0, 4, 1'b1);
      enable = 1'b1;
      drain();

      check("tmo0_idle", t0_cnt, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
